// File: rtl/md5_guess_generator.sv
// md5_guess_generator
//   Candidate source for one MD5 cracking lane. Walks lowercase passwords
//   a..z, aa..zz, ... in bijective base-26 order. It starts at a lane offset
//   and steps by a lane stride, so parallel lanes split the keyspace between
//   them. Each candidate is presented left-aligned in a 128-bit word through a
//   valid/ready handshake.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   start          1-cycle pulse; starts enumeration from IDLE or DONE
//   start_position lane offset: the first guess is index start_position ("a" = 0)
//   increment      lane stride 1..7; 0 is treated as 1
//   found          comparator match; stops the lane
//   guess_ready    encrypter accepts the current word
//   guess_valid    guess/guess_bits hold a valid candidate
//   guess          candidate; first char in [127:120], unused bytes zero
//   guess_bits     candidate length in bits
//   busy           high while seeding or issuing
//   done           high once stopped
//   exhausted      stop was caused by keyspace overflow
//   guess_count    accepted handshakes since start (saturating)
module md5_guess_generator #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] CHAR_BASE = 8'h61
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   start_position,
  input  logic [2:0]   increment,
  input  logic         found,
  input  logic         guess_ready,
  output logic         guess_valid,
  output logic [127:0] guess,
  output logic [7:0]   guess_bits,
  output logic         busy,
  output logic         done,
  output logic         exhausted,
  output logic [31:0]  guess_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_ISSUE, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [MAX_LEN-1:0][4:0]    digits_q, digits_d;   // [0] is the last char, 0 = empty
  logic [7:0]                 seed_cnt_q, seed_cnt_d;
  logic [2:0]                 stride_q, stride_d;
  logic                       valid_q, valid_d;
  logic [127:0]               guess_q, guess_d;
  logic [7:0]                 bits_q, bits_d;
  logic                       exhausted_q, exhausted_d;
  logic [31:0]                count_q, count_d;

  // Single ripple adder shared by seeding (adds 1) and issuing (adds stride).
  logic [2:0]                 add_k;
  logic [MAX_LEN-1:0][4:0]    sum_digits;
  logic                       add_ovf;
  logic [5:0]                 add_acc;
  logic [2:0]                 add_c;

  assign add_k = (state_q == S_SEED) ? 3'd1 : stride_q;

  always_comb begin
    sum_digits = '0;
    add_acc    = '0;
    add_c      = add_k;
    for (int i = 0; i < MAX_LEN; i++) begin
      add_acc = {1'b0, digits_q[i]} + {3'b000, add_c};
      if (add_acc > 6'd26) begin
        sum_digits[i] = 5'(add_acc - 6'd26);
        add_c         = 3'd1;
      end else begin
        sum_digits[i] = add_acc[4:0];
        add_c         = 3'd0;
      end
    end
    add_ovf = (add_c != 3'd0);
  end

  // Packer: while issuing, the next word comes from the adder output so a new
  // candidate can be presented every clock; otherwise from the held digits.
  logic [MAX_LEN-1:0][4:0]    pack_in;
  logic [127:0]               pack_word;
  logic [7:0]                 pack_bits;
  int                         pack_len;

  assign pack_in = (state_q == S_ISSUE && valid_q) ? sum_digits : digits_q;

  always_comb begin
    pack_len  = 0;
    pack_word = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (pack_in[i] != 5'd0) pack_len = i + 1;
    end
    // Byte j from the top carries digit len-1-j (most significant char first).
    for (int j = 0; j < MAX_LEN; j++) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (j < pack_len && i == pack_len - 1 - j)
          pack_word[127-8*j -: 8] = CHAR_BASE + {3'b000, pack_in[i]} - 8'd1;
      end
    end
    pack_bits = 8'(8 * pack_len);
  end

  logic hs;
  assign hs = valid_q & guess_ready;

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    seed_cnt_d  = seed_cnt_q;
    stride_d    = stride_q;
    valid_d     = valid_q;
    guess_d     = guess_q;
    bits_d      = bits_q;
    exhausted_d = exhausted_q;
    count_d     = count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_SEED;
          digits_d    = '0;
          digits_d[0] = 5'd1;
          seed_cnt_d  = start_position;
          stride_d    = (increment == 3'd0) ? 3'd1 : increment;
          exhausted_d = 1'b0;
          count_d     = '0;
          valid_d     = 1'b0;
        end
      end
      S_SEED: begin
        if (seed_cnt_q != 8'd0) begin
          digits_d   = sum_digits;
          seed_cnt_d = seed_cnt_q - 8'd1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!valid_q) begin
          // First cycle in ISSUE registers the seeded candidate.
          valid_d = 1'b1;
          guess_d = pack_word;
          bits_d  = pack_bits;
        end else if (hs) begin
          if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
          if (add_ovf) begin
            state_d     = S_DONE;
            exhausted_d = 1'b1;
            valid_d     = 1'b0;
          end else begin
            digits_d = sum_digits;
            guess_d  = pack_word;
            bits_d   = pack_bits;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // found outranks overflow; a same-edge handshake has already been counted.
    // The last presented guess is kept on the outputs.
    if (found && state_q != S_IDLE && !(state_q == S_DONE && start)) begin
      state_d     = S_DONE;
      valid_d     = 1'b0;
      exhausted_d = 1'b0;
      guess_d     = guess_q;
      bits_d      = bits_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      digits_q    <= '0;
      seed_cnt_q  <= '0;
      stride_q    <= 3'd1;
      valid_q     <= 1'b0;
      guess_q     <= '0;
      bits_q      <= '0;
      exhausted_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      seed_cnt_q  <= seed_cnt_d;
      stride_q    <= stride_d;
      valid_q     <= valid_d;
      guess_q     <= guess_d;
      bits_q      <= bits_d;
      exhausted_q <= exhausted_d;
      count_q     <= count_d;
    end
  end

  assign guess_valid = valid_q;
  assign guess       = guess_q;
  assign guess_bits  = bits_q;
  assign busy        = (state_q == S_SEED) || (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);
  assign exhausted   = exhausted_q;
  assign guess_count = count_q;

endmodule

// File: tb/tb_md5_guess_generator.sv
module tb_md5_guess_generator;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   start_position;
    logic [2:0]   increment;
    logic         found;
    logic         guess_ready;

    logic         guess_valid,  busy,  done,  exhausted;
    logic [127:0] guess;
    logic [7:0]   guess_bits;
    logic [31:0]  guess_count;

    logic         guess_valid2, busy2, done2, exhausted2;
    logic [127:0] guess2;
    logic [7:0]   guess_bits2;
    logic [31:0]  guess_count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    md5_guess_generator dut (
        .clock(clock), .reset(reset), .start(start),
        .start_position(start_position), .increment(increment),
        .found(found), .guess_ready(guess_ready),
        .guess_valid(guess_valid), .guess(guess), .guess_bits(guess_bits),
        .busy(busy), .done(done), .exhausted(exhausted), .guess_count(guess_count)
    );

    md5_guess_generator #(.MAX_LEN(2)) dut2 (
        .clock(clock), .reset(reset), .start(start),
        .start_position(start_position), .increment(increment),
        .found(found), .guess_ready(guess_ready),
        .guess_valid(guess_valid2), .guess(guess2), .guess_bits(guess_bits2),
        .busy(busy2), .done(done2), .exhausted(exhausted2), .guess_count(guess_count2)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    function automatic logic [127:0] str_word(input string s);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < s.len(); j++) w[127-8*j -: 8] = s[j];
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns at the negedge right after the edge that sampled start.
    task automatic pulse_start(input logic [7:0] sp, input logic [2:0] inc);
        @(negedge clock);
        start_position = sp;
        increment      = inc;
        start          = 1'b1;
        @(negedge clock);
        start          = 1'b0;
    endtask

    // Counts rising edges until guess_valid is seen, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!guess_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; start_position = '0; increment = 3'd1;
        found = 1'b0; guess_ready = 1'b0;
        #12;
        check_eq("rst_valid", guess_valid, 1'b0);
        check_eq("rst_guess", guess, '0);
        check_eq("rst_bits", guess_bits, 8'd0);
        check_eq("rst_busy_done", {busy, done, exhausted}, 3'b000);
        check_eq("rst_count", guess_count, 32'd0);
        reset = 1'b0;

        // 1: sp=0 inc=1, a..z then aa
        guess_ready = 1'b1;
        pulse_start(8'd0, 3'd1);
        wait_valid(n);
        check_eq("t1_latency", n, 2);
        for (int k = 0; k <= 26; k++) begin
            case (k)
                0: begin
                    check_eq("t1_a", guess, str_word("a"));
                    check_eq("t1_a_bits", guess_bits, 8'd8);
                    check_eq("t1_a_count", guess_count, 32'd0);
                    check_eq("t1_busy", busy, 1'b1);
                end
                1:  check_eq("t1_b", guess, str_word("b"));
                25: check_eq("t1_z", guess, str_word("z"));
                26: begin
                    check_eq("t1_aa", guess, str_word("aa"));
                    check_eq("t1_aa_bits", guess_bits, 8'd16);
                    check_eq("t1_aa_count", guess_count, 32'd26);
                    check_eq("t1_aa_valid", guess_valid, 1'b1);
                end
                default: ;
            endcase
            if (k < 26) @(negedge clock);
        end

        // 2: sp=25 -> first guess z at edge 27, then aa
        do_reset();
        pulse_start(8'd25, 3'd1);
        wait_valid(n);
        check_eq("t2_latency", n, 27);
        check_eq("t2_z", guess, str_word("z"));
        @(negedge clock);
        check_eq("t2_aa", guess, str_word("aa"));

        // 3: stride 3 -> a, d, ..., y, ab
        do_reset();
        pulse_start(8'd0, 3'd3);
        wait_valid(n);
        for (int k = 0; k <= 9; k++) begin
            case (k)
                0: check_eq("t3_a", guess, str_word("a"));
                1: check_eq("t3_d", guess, str_word("d"));
                8: check_eq("t3_y", guess, str_word("y"));
                9: begin
                    check_eq("t3_ab", guess, str_word("ab"));
                    check_eq("t3_ab_bits", guess_bits, 8'd16);
                end
                default: ;
            endcase
            if (k < 9) @(negedge clock);
        end

        // 4: MAX_LEN=2 instance runs out of keyspace after zz
        do_reset();
        pulse_start(8'd0, 3'd1);
        n = 0;
        while (!done2 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check_eq("t4_done", done2, 1'b1);
        check_eq("t4_exhausted", exhausted2, 1'b1);
        check_eq("t4_valid", guess_valid2, 1'b0);
        check_eq("t4_count", guess_count2, 32'd702);
        check_eq("t4_last", guess2, str_word("zz"));
        check_eq("t4_busy", busy2, 1'b0);

        // 5: stall with ready low, start ignored while busy, then found+ready
        do_reset();
        guess_ready = 1'b0;
        pulse_start(8'd0, 3'd1);
        wait_valid(n);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        check_eq("t5_hold_guess", guess, str_word("a"));
        check_eq("t5_hold_valid", guess_valid, 1'b1);
        check_eq("t5_hold_count", guess_count, 32'd0);
        found = 1'b1;
        guess_ready = 1'b1;
        @(negedge clock);
        found = 1'b0;
        check_eq("t5_count", guess_count, 32'd1);
        check_eq("t5_done", done, 1'b1);
        check_eq("t5_exhausted", exhausted, 1'b0);
        check_eq("t5_valid", guess_valid, 1'b0);
        check_eq("t5_keep_guess", guess, str_word("a"));

        // 6: asynchronous reset mid-ISSUE, then restart at a
        do_reset();
        pulse_start(8'd0, 3'd1);
        wait_valid(n);
        repeat (3) @(negedge clock);
        check_eq("t6_pre_guess", guess, str_word("d"));
        check_eq("t6_pre_count", guess_count, 32'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_async_valid", guess_valid, 1'b0);
        check_eq("t6_async_guess", guess, '0);
        check_eq("t6_async_misc", {busy, done, exhausted, guess_bits}, 11'd0);
        check_eq("t6_async_count", guess_count, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulse_start(8'd0, 3'd1);
        wait_valid(n);
        check_eq("t6_restart_latency", n, 2);
        check_eq("t6_restart_a", guess, str_word("a"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
